fpga_test_step_acc_round_sat: RTL and testbench



---
 rtl/fpga_test_step_acc_pkg.sv | 27 ++
 rtl/fpga_test_step_round_sat.sv | 32 +++
 rtl/fpga_test_step_acc_round_sat.sv | 139 +++++++++++++
 tb/tb_fpga_test_step_acc_round_sat.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fpga_test_step_acc_pkg.sv
// Shared widths, FSM state type and rounding/saturation constants for the
// fpga_test_step product accumulator.
package fpga_test_step_acc_pkg;

  localparam int unsigned IN_W       = 58;
  localparam int unsigned LEN_W      = 16;
  localparam int unsigned ACC_W      = 74;
  localparam int unsigned FRAC_SHIFT = 28;
  localparam int unsigned OUT_W      = 30;

  // The accumulator must hold 2^LEN_W full-scale products without wrapping.
  localparam bit ACC_W_OK = (ACC_W >= IN_W + LEN_W) && (FRAC_SHIFT >= 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Half an output LSB, added before the arithmetic shift (round half up).
  localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(1) << (FRAC_SHIFT - 1);

endpackage

// File: rtl/fpga_test_step_round_sat.sv
// Combinational round-half-up, arithmetic right shift and signed saturation
// of the wide accumulator down to the OUT_W result.
module fpga_test_step_round_sat
  import fpga_test_step_acc_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] res_o,
  output logic                    sat_o
);

  localparam logic signed [ACC_W-1:0] MAX_W = ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0] MIN_W = ACC_W'(OUT_MIN);

  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] shr_c;

  assign sum_c = acc_i + ROUND_K;
  assign shr_c = sum_c >>> FRAC_SHIFT;

  always_comb begin
    res_o = shr_c[OUT_W-1:0];
    sat_o = 1'b0;
    if (shr_c > MAX_W) begin
      res_o = OUT_MAX;
      sat_o = 1'b1;
    end else if (shr_c < MIN_W) begin
      res_o = OUT_MIN;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/fpga_test_step_acc_round_sat.sv
// Accumulates a configurable run of signed products, then rounds, shifts and
// saturates the sum onto a valid/ready result port.
module fpga_test_step_acc_round_sat
  import fpga_test_step_acc_pkg::*;
(
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic signed [IN_W-1:0]  prod_tdata,
  input  logic                    prod_tvalid,
  output logic                    prod_tready,
  output logic signed [OUT_W-1:0] out_tdata,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic                    out_sat,
  output logic                    busy
);

  if (!ACC_W_OK) begin : g_acc_w_chk
    $error("fpga_test_step_acc_round_sat: ACC_W must be >= IN_W + LEN_W and FRAC_SHIFT >= 1");
  end

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]        count_q, count_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic                    out_valid_q, out_valid_d;

  logic                    beat_c;
  logic [LEN_W-1:0]        eff_len_c;
  logic [LEN_W-1:0]        count_inc_c;
  logic signed [ACC_W-1:0] prod_ext_c;
  logic signed [OUT_W-1:0] rnd_data_c;
  logic                    rnd_sat_c;

  assign beat_c      = prod_tvalid & prod_tready;
  assign eff_len_c   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign count_inc_c = LEN_W'(count_q + LEN_W'(1));
  assign prod_ext_c  = ACC_W'(prod_tdata);

  fpga_test_step_round_sat u_round_sat (
    .acc_i (acc_q),
    .res_o (rnd_data_c),
    .sat_o (rnd_sat_c)
  );

  // State register
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat_c) state_d = (eff_len_c == LEN_W'(1)) ? ROUND : ACC;
      ACC:     if (beat_c && (count_inc_c == len_q)) state_d = ROUND;
      ROUND:   state_d = OUT;
      OUT:     if (out_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    prod_tready = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE:    prod_tready = 1'b1;
      ACC:     begin prod_tready = 1'b1; busy = 1'b1; end
      ROUND:   busy = 1'b1;
      OUT:     busy = 1'b1;
      default: ;
    endcase
  end

  // Accumulator, beat counter and result register updates
  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    len_d       = len_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (beat_c) begin
          len_d   = eff_len_c;
          acc_d   = prod_ext_c;
          count_d = LEN_W'(1);
        end
      end
      ACC: begin
        if (beat_c) begin
          acc_d   = acc_q + prod_ext_c;
          count_d = count_inc_c;
        end
      end
      ROUND: begin
        out_data_d  = rnd_data_c;
        out_sat_d   = rnd_sat_c;
        out_valid_d = 1'b1;
      end
      OUT: begin
        if (out_tready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc_q       <= '0;
      count_q     <= '0;
      len_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_tdata  = out_data_q;
  assign out_sat    = out_sat_q;
  assign out_tvalid = out_valid_q;

endmodule

// File: tb/tb_fpga_test_step_acc_round_sat.sv
// Directed self-checking bench for the product accumulate/round/saturate stage.
module tb_fpga_test_step_acc_round_sat;

  localparam int unsigned IN_W  = 58;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned OUT_W = 30;
  localparam longint      S     = longint'(1) <<< 28;
  localparam longint      H     = longint'(1) <<< 27;
  localparam longint      P56   = longint'(1) <<< 56;

  logic                    ap_clk = 1'b0;
  logic                    ap_rst_n;
  logic [LEN_W-1:0]        cfg_len;
  logic signed [IN_W-1:0]  prod_tdata;
  logic                    prod_tvalid;
  logic                    prod_tready;
  logic signed [OUT_W-1:0] out_tdata;
  logic                    out_tvalid;
  logic                    out_tready;
  logic                    out_sat;
  logic                    busy;

  int total = 0;
  int bad   = 0;

  fpga_test_step_acc_round_sat dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .cfg_len     (cfg_len),
    .prod_tdata  (prod_tdata),
    .prod_tvalid (prod_tvalid),
    .prod_tready (prod_tready),
    .out_tdata   (out_tdata),
    .out_tvalid  (out_tvalid),
    .out_tready  (out_tready),
    .out_sat     (out_sat),
    .busy        (busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input string tag, input longint v);
    bit got;
    got         = 1'b0;
    prod_tdata  = IN_W'(v);
    prod_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (prod_tready) begin
        got = 1'b1;
        tick();
        break;
      end
      tick();
    end
    prod_tvalid = 1'b0;
    if (!got) check({tag, "_beat_timeout"}, 0, 1);
  endtask

  // Called right after the last beat edge: ROUND now, result one edge later.
  task automatic check_result(input string tag, input longint exp, input longint exp_sat);
    check({tag, "_round_valid"}, longint'(out_tvalid), 0);
    check({tag, "_round_ready"}, longint'(prod_tready), 0);
    tick();
    check({tag, "_valid"}, longint'(out_tvalid), 1);
    check({tag, "_data"}, longint'(out_tdata), exp);
    check({tag, "_sat"}, longint'(out_sat), exp_sat);
    check({tag, "_out_ready"}, longint'(prod_tready), 0);
    if (out_tready) begin
      tick();
      check({tag, "_done_valid"}, longint'(out_tvalid), 0);
      check({tag, "_done_busy"}, longint'(busy), 0);
    end
  endtask

  task automatic run1(input string tag, input int len, input longint v,
                      input longint exp, input longint exp_sat);
    cfg_len = LEN_W'(len);
    send_beat(tag, v);
    check_result(tag, exp, exp_sat);
  endtask

  initial begin
    ap_rst_n    = 1'b0;
    cfg_len     = '0;
    prod_tdata  = '0;
    prod_tvalid = 1'b0;
    out_tready  = 1'b1;
    tick();
    tick();
    check("rst_valid", longint'(out_tvalid), 0);
    check("rst_data", longint'(out_tdata), 0);
    check("rst_sat", longint'(out_sat), 0);
    check("rst_busy", longint'(busy), 0);
    ap_rst_n = 1'b1;
    tick();
    check("idle_ready", longint'(prod_tready), 1);

    // Single beat and rounding corners
    run1("single", 1, 3 * S, 3, 0);
    run1("rnd_p_half", 1, H, 1, 0);
    run1("rnd_n_half", 1, -H, 0, 0);
    run1("rnd_p_3half", 1, 3 * H, 2, 0);
    run1("rnd_n_3half", 1, -3 * H, -1, 0);
    run1("edge_max", 1, ((longint'(1) <<< 29) - 1) * S, 536870911, 0);
    run1("edge_min", 1, -(longint'(1) <<< 57), -536870912, 0);

    // Saturation on four full-scale beats
    cfg_len = LEN_W'(4);
    for (int i = 0; i < 4; i++) send_beat("sat_pos", P56);
    check_result("sat_pos", 536870911, 1);
    cfg_len = LEN_W'(4);
    for (int i = 0; i < 4; i++) send_beat("sat_neg", -P56);
    check_result("sat_neg", -536870912, 1);

    // Gapped accumulation; cfg_len change after the first beat is ignored
    cfg_len = LEN_W'(5);
    send_beat("stall", S);
    cfg_len = LEN_W'(2);
    for (int k = 2; k <= 5; k++) begin
      int gap;
      gap = int'($urandom_range(1, 3));
      for (int g = 0; g < gap; g++) tick();
      check("stall_busy", longint'(busy), 1);
      check("stall_ready", longint'(prod_tready), 1);
      send_beat("stall", longint'(k) * S);
    end
    check_result("stall", 15, 0);

    // Output backpressure holds the result and blocks new beats
    out_tready = 1'b0;
    run1("bp", 1, 7 * S, 7, 0);
    prod_tdata  = IN_W'(9 * S);
    prod_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_hold_valid", longint'(out_tvalid), 1);
      check("bp_hold_data", longint'(out_tdata), 7);
      check("bp_hold_ready", longint'(prod_tready), 0);
    end
    prod_tvalid = 1'b0;
    out_tready  = 1'b1;
    tick();
    check("bp_rel_valid", longint'(out_tvalid), 0);
    check("bp_rel_busy", longint'(busy), 0);
    run1("len0", 0, -5 * S, -5, 0);

    // Reset in the middle of a run discards the partial sum
    cfg_len = LEN_W'(8);
    for (int i = 0; i < 3; i++) send_beat("abort", 100 * S);
    check("abort_busy", longint'(busy), 1);
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    check("abort_valid", longint'(out_tvalid), 0);
    check("abort_data", longint'(out_tdata), 0);
    check("abort_sat", longint'(out_sat), 0);
    check("abort_busy0", longint'(busy), 0);
    cfg_len = LEN_W'(2);
    send_beat("fresh", S);
    check("fresh_mid_busy", longint'(busy), 1);
    send_beat("fresh", S);
    check_result("fresh", 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
